// File: rtl/armleocpu_loadunit_if.sv
// Load-unit bus bundle: request from execute, memory read port, result back to execute.
// The unit itself uses the slave modport; the environment side uses master.
interface armleocpu_loadunit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [31:0]     req_addr;
   logic [2:0]      req_type;
   logic            mem_valid;
   logic            mem_ready;
   logic [31:0]     mem_addr;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_rerror;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic            resp_missaligned;
   logic            resp_unknowntype;
   logic            resp_accessfault;

   modport slave (
      input  req_valid, req_addr, req_type, mem_ready, mem_rvalid, mem_rdata, mem_rerror, resp_ready,
      output req_ready, mem_valid, mem_addr, resp_valid, resp_data,
             resp_missaligned, resp_unknowntype, resp_accessfault
   );

   modport master (
      output req_valid, req_addr, req_type, mem_ready, mem_rvalid, mem_rdata, mem_rerror, resp_ready,
      input  req_ready, mem_valid, mem_addr, resp_valid, resp_data,
             resp_missaligned, resp_unknowntype, resp_accessfault
   );
endinterface

// File: rtl/armleocpu_loadunit.sv
// Load path: one request at a time, one or two aligned beats, merge/shift/extend,
// result with exception flags. All outputs are registered.
module armleocpu_loadunit #(
   parameter int XLEN             = 32,
   parameter int MISALIGNED_SPLIT = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   armleocpu_loadunit_if.slave bus
);
   localparam int W  = XLEN / 8;
   localparam int OW = $clog2(W);
   localparam int IW = $clog2(2 * XLEN);

   typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

   state_t          state;
   logic [OW-1:0]   off;
   logic [2:0]      type_q;
   logic [XLEN-1:0] low_q;

   logic            illegal_in;
   logic            misal_in;
   logic [2:0]      amask_in;

   always_comb begin
      amask_in = 3'b000;
      case (bus.req_type[1:0])
         2'd1:    amask_in = 3'b001;
         2'd2:    amask_in = 3'b011;
         2'd3:    amask_in = 3'b111;
         default: amask_in = 3'b000;
      endcase
      misal_in   = |(bus.req_addr[2:0] & amask_in);
      illegal_in = (bus.req_type == 3'b111) ||
                   ((XLEN == 32) && (bus.req_type == 3'b011 || bus.req_type == 3'b110));
   end

   logic [4:0] size_b;
   logic       split_need;
   assign size_b     = 5'd1 << type_q[1:0];
   assign split_need = (5'(off) + size_b) > 5'(W);

   // Result is built straight from the incoming beat, so RESP is entered with data ready.
   logic [2*XLEN-1:0] merged;
   logic [2*XLEN-1:0] shifted;
   logic [XLEN-1:0]   ext;
   logic [6:0]        nbits;
   logic [IW-1:0]     sidx;
   logic              sbit;

   always_comb begin
      merged  = (state == WAIT2) ? {bus.mem_rdata, low_q} : {{XLEN{1'b0}}, bus.mem_rdata};
      shifted = merged >> {off, 3'b000};
      nbits   = 7'd8 << type_q[1:0];
      sidx    = IW'(nbits - 7'd1);
      sbit    = shifted[sidx] & ~type_q[2];
      ext     = shifted[XLEN-1:0];
      for (int i = 0; i < XLEN; i++)
         if (7'(i) >= nbits) ext[i] = sbit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= IDLE;
         off                  <= '0;
         type_q               <= '0;
         low_q                <= '0;
         bus.req_ready        <= 1'b1;
         bus.mem_valid        <= 1'b0;
         bus.mem_addr         <= '0;
         bus.resp_valid       <= 1'b0;
         bus.resp_data        <= '0;
         bus.resp_missaligned <= 1'b0;
         bus.resp_unknowntype <= 1'b0;
         bus.resp_accessfault <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               off           <= bus.req_addr[OW-1:0];
               type_q        <= bus.req_type;
               bus.req_ready <= 1'b0;
               if (illegal_in) begin
                  state                <= RESP;
                  bus.resp_valid       <= 1'b1;
                  bus.resp_unknowntype <= 1'b1;
               end else if (misal_in && MISALIGNED_SPLIT == 0) begin
                  state                <= RESP;
                  bus.resp_valid       <= 1'b1;
                  bus.resp_missaligned <= 1'b1;
               end else begin
                  state         <= REQ1;
                  bus.mem_valid <= 1'b1;
                  bus.mem_addr  <= bus.req_addr & ~32'(W - 1);
               end
            end
            REQ1: if (bus.mem_ready) begin
               bus.mem_valid <= 1'b0;
               state         <= WAIT1;
            end
            WAIT1: if (bus.mem_rvalid) begin
               if (bus.mem_rerror) begin
                  state                <= RESP;
                  bus.resp_valid       <= 1'b1;
                  bus.resp_accessfault <= 1'b1;
               end else if (split_need) begin
                  low_q         <= bus.mem_rdata;
                  state         <= REQ2;
                  bus.mem_valid <= 1'b1;
                  bus.mem_addr  <= bus.mem_addr + 32'(W);
               end else begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= ext;
               end
            end
            REQ2: if (bus.mem_ready) begin
               bus.mem_valid <= 1'b0;
               state         <= WAIT2;
            end
            WAIT2: if (bus.mem_rvalid) begin
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               if (bus.mem_rerror) bus.resp_accessfault <= 1'b1;
               else                bus.resp_data        <= ext;
            end
            RESP: if (bus.resp_ready) begin
               state                <= IDLE;
               bus.req_ready        <= 1'b1;
               bus.resp_valid       <= 1'b0;
               bus.resp_data        <= '0;
               bus.resp_missaligned <= 1'b0;
               bus.resp_unknowntype <= 1'b0;
               bus.resp_accessfault <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_armleocpu_loadunit.sv
// Scoreboard bench: XLEN=32 split unit and XLEN=64 non-split unit against a byte-level memory model.
module tb_armleocpu_loadunit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   armleocpu_loadunit_if #(.XLEN(32)) b32 ();
   armleocpu_loadunit_if #(.XLEN(64)) b64 ();

   armleocpu_loadunit #(.XLEN(32), .MISALIGNED_SPLIT(1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   armleocpu_loadunit #(.XLEN(64), .MISALIGNED_SPLIT(0)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

   typedef struct {
      logic [63:0] d;
      logic [2:0]  f;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int          stall_cfg = 0;
   int          rvd_cfg = 0;
   int          err_at32 = -1;
   int          err_at64 = -1;
   logic [7:0]  ovr[logic [31:0]];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] mbyte(input logic [31:0] a);
      if (ovr.exists(a)) return ovr[a];
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
   endfunction

   function automatic logic [31:0] beat32(input logic [31:0] a);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mbyte(a + 32'(i));
      return v;
   endfunction

   function automatic logic [63:0] beat64(input logic [31:0] a);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = mbyte(a + 32'(i));
      return v;
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) ovr[a + 32'(i)] = w[8*i +: 8];
   endtask

   // Reference result assembled byte by byte from the memory model.
   function automatic void model(input int xlen, input int split, input logic [31:0] a,
                                 input logic [2:0] t, input int errb,
                                 output logic [63:0] d, output logic [2:0] f, output int nb);
      int s, w, off;
      s = 1 << t[1:0];
      w = xlen / 8;
      off = int'(a[2:0]) & (w - 1);
      d = '0; f = '0; nb = 0;
      if (t == 3'b111 || (xlen == 32 && (t == 3'b011 || t == 3'b110))) begin f = 3'b010; return; end
      if ((int'(a[2:0]) & (s - 1)) != 0 && split == 0) begin f = 3'b100; return; end
      nb = (off + s > w) ? 2 : 1;
      if (errb >= 0 && errb < nb) begin f = 3'b001; nb = errb + 1; return; end
      for (int i = 0; i < s; i++) d[8*i +: 8] = mbyte(a + 32'(i));
      if (!t[2] && s * 8 < xlen && d[8*s-1])
         for (int i = 8 * s; i < xlen; i++) d[i] = 1'b1;
   endfunction

   int          hs32 = 0, mv32 = 0, stc32 = 0, bad32 = 0, rvc32 = 0;
   logic        pend32 = 1'b0, perr32 = 1'b0;
   logic [31:0] pdat32, last32;
   logic [31:0] alog32[$];

   always @(posedge clk) begin
      b32.mem_rvalid <= 1'b0;
      b32.mem_rerror <= 1'b0;
      if (b32.mem_valid) mv32 <= mv32 + 1;
      if (pend32) begin
         if (rvc32 == 0) begin
            b32.mem_rvalid <= 1'b1; b32.mem_rdata <= pdat32; b32.mem_rerror <= perr32; pend32 <= 1'b0;
         end else rvc32 <= rvc32 - 1;
      end
      if (b32.mem_valid && b32.mem_ready) begin
         alog32.push_back(b32.mem_addr);
         hs32 <= hs32 + 1;
         b32.mem_ready <= (stall_cfg == 0);
         stc32 <= 0;
         if (rvd_cfg == 0) begin
            b32.mem_rvalid <= 1'b1; b32.mem_rdata <= beat32(b32.mem_addr); b32.mem_rerror <= (hs32 == err_at32);
         end else begin
            pend32 <= 1'b1; rvc32 <= rvd_cfg - 1; pdat32 <= beat32(b32.mem_addr); perr32 <= (hs32 == err_at32);
         end
      end else if (b32.mem_valid) begin
         if (stc32 > 0 && b32.mem_addr != last32) bad32 <= bad32 + 1;
         last32 <= b32.mem_addr;
         stc32 <= stc32 + 1;
         b32.mem_ready <= (stc32 + 1 >= stall_cfg);
      end else begin
         b32.mem_ready <= (stall_cfg == 0);
         stc32 <= 0;
      end
   end

   int          hs64 = 0, mv64 = 0, stc64 = 0, rvc64 = 0;
   logic        pend64 = 1'b0, perr64 = 1'b0;
   logic [63:0] pdat64;

   always @(posedge clk) begin
      b64.mem_rvalid <= 1'b0;
      b64.mem_rerror <= 1'b0;
      if (b64.mem_valid) mv64 <= mv64 + 1;
      if (pend64) begin
         if (rvc64 == 0) begin
            b64.mem_rvalid <= 1'b1; b64.mem_rdata <= pdat64; b64.mem_rerror <= perr64; pend64 <= 1'b0;
         end else rvc64 <= rvc64 - 1;
      end
      if (b64.mem_valid && b64.mem_ready) begin
         hs64 <= hs64 + 1;
         b64.mem_ready <= (stall_cfg == 0);
         stc64 <= 0;
         if (rvd_cfg == 0) begin
            b64.mem_rvalid <= 1'b1; b64.mem_rdata <= beat64(b64.mem_addr); b64.mem_rerror <= (hs64 == err_at64);
         end else begin
            pend64 <= 1'b1; rvc64 <= rvd_cfg - 1; pdat64 <= beat64(b64.mem_addr); perr64 <= (hs64 == err_at64);
         end
      end else if (b64.mem_valid) begin
         stc64 <= stc64 + 1;
         b64.mem_ready <= (stc64 + 1 >= stall_cfg);
      end else begin
         b64.mem_ready <= (stall_cfg == 0);
         stc64 <= 0;
      end
   end

   function automatic logic [63:0] rdy(input int s);
      return 64'(s == 0 ? b32.req_ready : b64.req_ready);
   endfunction
   function automatic logic [63:0] rv(input int s);
      return 64'(s == 0 ? b32.resp_valid : b64.resp_valid);
   endfunction
   function automatic logic [63:0] mvf(input int s);
      return 64'(s == 0 ? b32.mem_valid : b64.mem_valid);
   endfunction
   function automatic logic [63:0] maf(input int s);
      return 64'(s == 0 ? b32.mem_addr : b64.mem_addr);
   endfunction
   function automatic logic [63:0] rd(input int s);
      return s == 0 ? {32'h0, b32.resp_data} : b64.resp_data;
   endfunction
   function automatic logic [63:0] rf(input int s);
      if (s == 0) return 64'({b32.resp_missaligned, b32.resp_unknowntype, b32.resp_accessfault});
      return 64'({b64.resp_missaligned, b64.resp_unknowntype, b64.resp_accessfault});
   endfunction

   task automatic check_reset(input int s);
      chk("rst_req_ready", rdy(s), 64'd1);
      chk("rst_mem_valid", mvf(s), 64'd0);
      chk("rst_mem_addr", maf(s), 64'd0);
      chk("rst_resp_valid", rv(s), 64'd0);
      chk("rst_resp_data", rd(s), 64'd0);
      chk("rst_flags", rf(s), 64'd0);
   endtask

   task automatic drive_req(input int s, input logic [31:0] a, input logic [2:0] t);
      int n;
      if (s == 0) begin b32.req_valid = 1'b1; b32.req_addr = a; b32.req_type = t; end
      else        begin b64.req_valid = 1'b1; b64.req_addr = a; b64.req_type = t; end
      n = 0;
      while (rdy(s) == 64'd0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("req_ready", rdy(s), 64'd1);
      @(posedge clk); #1;
      b32.req_valid = 1'b0;
      b64.req_valid = 1'b0;
   endtask

   task automatic do_load(input int s, input logic [31:0] a, input logic [2:0] t,
                          input logic [63:0] ed, input logic [2:0] ef, input int elat, input int hold);
      exp_t e;
      int   n;
      e.d = ed; e.f = ef; e.lat = elat;
      sbq.push_back(e);
      drive_req(s, a, t);
      n = 1;
      while (rv(s) == 64'd0 && n < 200) begin @(posedge clk); #1; n++; end
      chk("resp_valid", rv(s), 64'd1);
      e = sbq.pop_front();
      chk("resp_data", rd(s), e.d);
      chk("resp_flags", rf(s), 64'(e.f));
      if (e.lat >= 0) chk("latency", 64'(n), 64'(e.lat));
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         chk("hold_valid", rv(s), 64'd1);
         chk("hold_data", rd(s), e.d);
      end
      b32.resp_ready = 1'b1; b64.resp_ready = 1'b1;
      @(posedge clk); #1;
      b32.resp_ready = 1'b0; b64.resp_ready = 1'b0;
      chk("resp_release", rv(s), 64'd0);
   endtask

   initial begin
      int          h0, m0, b0, n, s, errb, nb;
      logic [31:0] a;
      logic [2:0]  t;
      logic [63:0] d;
      logic [2:0]  f;
      b32.req_valid = 1'b0; b32.req_addr = '0; b32.req_type = '0; b32.resp_ready = 1'b0;
      b64.req_valid = 1'b0; b64.req_addr = '0; b64.req_type = '0; b64.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      set_word(32'h100, 32'h8899AABB);
      do_load(0, 32'h100, 3'b010, 64'h8899AABB, 3'b000, 3, 0);
      set_word(32'h100, 32'h80123456);
      do_load(0, 32'h103, 3'b000, 64'hFFFFFF80, 3'b000, 3, 0);
      do_load(0, 32'h103, 3'b100, 64'h00000080, 3'b000, 3, 0);
      set_word(32'h100, 32'hF00D1234);
      do_load(0, 32'h102, 3'b101, 64'h0000F00D, 3'b000, 3, 0);

      set_word(32'h100, 32'hAABBCCDD);
      set_word(32'h104, 32'h11223344);
      alog32.delete(); h0 = hs32;
      do_load(0, 32'h102, 3'b010, 64'h3344AABB, 3'b000, 5, 0);
      chk("split_beats", 64'(hs32 - h0), 64'd2);
      chk("split_addr0", 64'(alog32[0]), 64'h100);
      chk("split_addr1", 64'(alog32[1]), 64'h104);
      do_load(0, 32'h103, 3'b001, 64'h000044AA, 3'b000, 5, 0);

      m0 = mv64;
      do_load(1, 32'h101, 3'b010, 64'h0, 3'b100, 1, 0);
      chk("misal_no_mem", 64'(mv64 - m0), 64'd0);
      m0 = mv32;
      do_load(0, 32'h100, 3'b111, 64'h0, 3'b010, 1, 0);
      do_load(0, 32'h100, 3'b011, 64'h0, 3'b010, 1, 0);
      chk("illegal_no_mem", 64'(mv32 - m0), 64'd0);

      set_word(32'h8, 32'h89ABCDEF);
      set_word(32'hC, 32'h01234567);
      do_load(1, 32'h8, 3'b011, 64'h0123456789ABCDEF, 3'b000, 3, 0);
      set_word(32'h10, 32'h80000001);
      do_load(1, 32'h10, 3'b110, 64'h0000000080000001, 3'b000, 3, 0);
      do_load(1, 32'h10, 3'b010, 64'hFFFFFFFF80000001, 3'b000, 3, 0);

      h0 = hs32; err_at32 = hs32;
      do_load(0, 32'h0FE, 3'b010, 64'h0, 3'b001, -1, 0);
      chk("fault_beats", 64'(hs32 - h0), 64'd1);
      err_at32 = -1;

      stall_cfg = 3; alog32.delete(); b0 = bad32;
      do_load(0, 32'h102, 3'b010, 64'h3344AABB, 3'b000, 11, 0);
      chk("stall_addr_stable", 64'(bad32 - b0), 64'd0);
      chk("stall_addr1", 64'(alog32[1]), 64'h104);
      stall_cfg = 0;

      do_load(0, 32'h100, 3'b010, 64'hAABBCCDD, 3'b000, 3, 4);

      alog32.delete();
      model(32, 1, 32'hFFFFFFFF, 3'b001, -1, d, f, nb);
      do_load(0, 32'hFFFFFFFF, 3'b001, d, f, 5, 0);
      chk("wrap_addr1", 64'(alog32[1]), 64'h0);

      // Abort a split load in WAIT2 while its second beat is still outstanding.
      rvd_cfg = 3; h0 = hs32;
      drive_req(0, 32'h102, 3'b010);
      n = 0;
      while (hs32 != h0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
      chk("abort_reach_wait2", 64'(hs32 - h0), 64'd2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset(0);
      #2 rst_n = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      chk("late_rvalid_dropped", rv(0), 64'd0);
      chk("idle_after_abort", rdy(0), 64'd1);
      rvd_cfg = 0;
      set_word(32'h200, 32'hCAFEF00D);
      do_load(0, 32'h200, 3'b010, 64'hCAFEF00D, 3'b000, 3, 0);

      for (int k = 0; k < 40; k++) begin
         s = k % 2;
         a = (k % 10 == 9) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : 32'h300 + 32'($urandom_range(0, 63));
         t = 3'($urandom_range(0, 7));
         errb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
         stall_cfg = int'($urandom_range(0, 2));
         rvd_cfg = int'($urandom_range(0, 2));
         model(s == 0 ? 32 : 64, s == 0 ? 1 : 0, a, t, errb, d, f, nb);
         h0 = (s == 0) ? hs32 : hs64;
         if (s == 0) err_at32 = (errb < 0) ? -1 : hs32 + errb;
         else        err_at64 = (errb < 0) ? -1 : hs64 + errb;
         do_load(s, a, t, d, f, -1, 0);
         chk("rand_beats", 64'(((s == 0) ? hs32 : hs64) - h0), 64'(nb));
      end
      err_at32 = -1; err_at64 = -1; stall_cfg = 0; rvd_cfg = 0;

      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
